// File: rtl/f1_start_seq_ctrl.sv
// F1 start-light sequencer with reaction timer.
// A millisecond tick is derived from clk. Lamps light one per STEP_MS, then
// stay lit for an LFSR-random number of ms, go dark, and the driver's
// reaction is timed in ms. An early press is a false start. No press within
// the counter range is reported as a timeout with an all-ones time.
// trigger and react are synchronous levels; only their rising edges act.
// dbg_state presents the FSM state for observation.
module f1_start_seq_ctrl #(
    parameter int                NUM_LIGHTS = 10,
    parameter int                TICK_DIV   = 50000,
    parameter int                STEP_MS    = 500,
    parameter int                LFSR_W     = 14,
    parameter logic [LFSR_W-1:0] LFSR_TAPS  = 14'h2015,
    parameter int                RT_W       = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trigger,
    input  logic                  react,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic [LFSR_W-1:0]     delay_ms,
    output logic [RT_W-1:0]       react_ms,
    output logic                  result_valid,
    output logic                  false_start,
    output logic                  busy,
    output logic [2:0]            dbg_state
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(STEP_MS + 1);

    localparam logic [PW-1:0]         PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0]         STEP_MAX  = SW'(STEP_MS - 1);
    localparam logic [RT_W-1:0]       RT_MAX    = '1;
    localparam logic [NUM_LIGHTS-1:0] ALL_ON    = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LIGHTS = 3'd1,
        S_HOLD   = 3'd2,
        S_TIMING = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic                    trig_q, react_q;
    logic [PW-1:0]           presc_q, presc_d;
    logic [SW-1:0]           step_q, step_d;
    logic [LFSR_W-1:0]       delay_q, delay_d;
    logic [RT_W-1:0]         rt_q, rt_d;
    logic [LFSR_W-1:0]       lfsr_q, lfsr_d;
    logic [NUM_LIGHTS-1:0]   lights_q, lights_d;
    logic [LFSR_W-1:0]       delay_ms_q, delay_ms_d;
    logic [RT_W-1:0]         react_ms_q, react_ms_d;
    logic                    valid_q, valid_d;
    logic                    fs_q, fs_d;
    logic                    busy_q, busy_d;

    logic trig_rise, react_rise, ms_tick;

    assign trig_rise  = trigger & ~trig_q;
    assign react_rise = react & ~react_q;
    assign ms_tick    = (presc_q == PRESC_MAX);

    // Next-state and output logic; a react rise in LIGHTS/HOLD beats any
    // same-cycle step or delay expiry.
    always_comb begin
        state_d    = state_q;
        presc_d    = ms_tick ? '0 : presc_q + PW'(1);
        step_d     = step_q;
        delay_d    = delay_q;
        rt_d       = rt_q;
        lfsr_d     = lfsr_q;
        lights_d   = lights_q;
        delay_ms_d = delay_ms_q;
        react_ms_d = react_ms_q;
        valid_d    = valid_q;
        fs_d       = fs_q;

        // The random source only runs while waiting for a start, so the
        // captured delay depends on how long the rig sat idle.
        if (state_q == S_IDLE || state_q == S_DONE) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (trig_rise) begin
                    state_d    = S_LIGHTS;
                    lights_d   = NUM_LIGHTS'(1);
                    valid_d    = 1'b0;
                    fs_d       = 1'b0;
                    react_ms_d = '0;
                    step_d     = '0;
                    presc_d    = '0;
                end
            end
            S_LIGHTS: begin
                if (react_rise) begin
                    state_d    = S_DONE;
                    fs_d       = 1'b1;
                    valid_d    = 1'b0;
                    react_ms_d = '0;
                    lights_d   = ALL_ON;
                end else if (ms_tick) begin
                    if (step_q == STEP_MAX) begin
                        step_d = '0;
                        if (lights_q != ALL_ON) begin
                            lights_d = {lights_q[NUM_LIGHTS-2:0], 1'b1};
                        end else begin
                            state_d    = S_HOLD;
                            delay_ms_d = lfsr_q;
                            delay_d    = lfsr_q;
                        end
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
            end
            S_HOLD: begin
                if (react_rise) begin
                    state_d    = S_DONE;
                    fs_d       = 1'b1;
                    valid_d    = 1'b0;
                    react_ms_d = '0;
                    lights_d   = ALL_ON;
                end else if (ms_tick) begin
                    if (delay_q == LFSR_W'(1)) begin
                        state_d  = S_TIMING;
                        lights_d = '0;
                        rt_d     = '0;
                        presc_d  = '0;
                    end else begin
                        delay_d = delay_q - LFSR_W'(1);
                    end
                end
            end
            S_TIMING: begin
                if (react_rise) begin
                    state_d    = S_DONE;
                    react_ms_d = rt_q;
                    valid_d    = 1'b1;
                end else if (ms_tick) begin
                    if (rt_q == RT_MAX) begin
                        state_d    = S_DONE;
                        react_ms_d = RT_MAX;
                        valid_d    = 1'b1;
                    end else begin
                        rt_d = rt_q + RT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_LIGHTS) || (state_d == S_HOLD) || (state_d == S_TIMING);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            trig_q     <= 1'b0;
            react_q    <= 1'b0;
            presc_q    <= '0;
            step_q     <= '0;
            delay_q    <= '0;
            rt_q       <= '0;
            lfsr_q     <= LFSR_W'(1);
            lights_q   <= '0;
            delay_ms_q <= '0;
            react_ms_q <= '0;
            valid_q    <= 1'b0;
            fs_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            trig_q     <= trigger;
            react_q    <= react;
            presc_q    <= presc_d;
            step_q     <= step_d;
            delay_q    <= delay_d;
            rt_q       <= rt_d;
            lfsr_q     <= lfsr_d;
            lights_q   <= lights_d;
            delay_ms_q <= delay_ms_d;
            react_ms_q <= react_ms_d;
            valid_q    <= valid_d;
            fs_q       <= fs_d;
            busy_q     <= busy_d;
        end
    end

    assign lights       = lights_q;
    assign delay_ms     = delay_ms_q;
    assign react_ms     = react_ms_q;
    assign result_valid = valid_q;
    assign false_start  = fs_q;
    assign busy         = busy_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_f1_start_seq_ctrl.sv
// Bench for f1_start_seq_ctrl with a small configuration (5 lamps, 4 clk per
// ms, 2 ms per lamp, 6-bit reaction counter). Each run is predicted from the
// timing rules: lamp count from elapsed cycles, lamps-out time from the
// captured delay, reaction time as whole ms elapsed since lamps out.
module tb_f1_start_seq_ctrl;

  localparam int NL = 5;
  localparam int TD = 4;
  localparam int SM = 2;
  localparam int LW = 14;
  localparam int RW = 6;
  localparam logic [LW-1:0] TAPS = 14'h2015;

  localparam int HOLD_REL = NL * SM * TD;      // trigger edge to HOLD entry
  localparam int TIMEOUT  = (1 << RW) * TD;    // lamps out to timeout
  localparam int RMAX     = (1 << RW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic trigger;
  logic react;
  logic [NL-1:0] lights;
  logic [LW-1:0] delay_ms;
  logic [RW-1:0] react_ms;
  logic result_valid;
  logic false_start;
  logic busy;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  f1_start_seq_ctrl #(
    .NUM_LIGHTS(NL),
    .TICK_DIV(TD),
    .STEP_MS(SM),
    .LFSR_W(LW),
    .LFSR_TAPS(TAPS),
    .RT_W(RW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .trigger(trigger),
    .react(react),
    .lights(lights),
    .delay_ms(delay_ms),
    .react_ms(react_ms),
    .result_valid(result_valid),
    .false_start(false_start),
    .busy(busy),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  logic [LW-1:0] m_lfsr;
  logic [LW-1:0] m_delay;
  bit m_idle;

  function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] l);
    return (l >> 1) ^ (l[0] ? TAPS : {LW{1'b0}});
  endfunction

  // Random source advances on every edge the sequencer is waiting for a start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 1;
    else if (m_idle) m_lfsr <= lfsr_step(m_lfsr);
  end

  // Lamps lit c cycles after the trigger edge, dark from lamps-out on.
  function automatic logic [NL-1:0] model_lights(input int c, input int e_rel);
    logic [NL-1:0] v;
    int k;
    v = '0;
    if (c >= e_rel) return v;
    k = 1 + c / (SM * TD);
    if (k > NL) k = NL;
    for (int i = 0; i < k; i++) v[i] = 1'b1;
    return v;
  endfunction

  // ---------------- driver: one complete start sequence ----------------
  // mode 0: no press; 1: press edge val cycles after trigger edge;
  // 2: press edge val cycles after lamps-out edge.
  task automatic do_run(input int mode, input int val, input bit same_react,
                        input int trig_edge, input int abort_off, input int minw);
    logic [LW-1:0] v, best;
    logic [NL-1:0] exp_l;
    logic [LW-1:0] exp_d;
    logic [NL+LW+RW+2:0] act_v, exp_v;
    int bj, e_rel, r, done, c, rms, abort_at;
    bit fs;

    // choose idle length so the captured delay is short
    v = m_lfsr;
    best = '1;
    bj = minw;
    for (int k = 0; k < minw + 4096; k++) begin
      v = lfsr_step(v);
      if (k >= minw && v < best) begin
        best = v;
        bj = k;
      end
      if (k >= minw && best < 64) break;
    end
    repeat (bj) @(negedge clk);
    trigger = 1'b1;
    if (same_react) react = 1'b1;
    @(negedge clk);
    m_idle = 1'b0;

    e_rel = HOLD_REL + int'(best) * TD;
    r = 0;
    if (mode == 1) r = val;
    if (mode == 2) r = e_rel + val;
    fs = 1'b0;
    rms = 0;
    if (r > 0 && r <= e_rel) begin
      fs = 1'b1;
      done = r;
    end else if (r > 0 && r - e_rel <= TIMEOUT) begin
      done = r;
      rms = (r - e_rel - 1) / TD;
      if (rms > RMAX) rms = RMAX;
    end else begin
      r = 0;
      done = e_rel + TIMEOUT;
      rms = RMAX;
    end
    abort_at = (abort_off > 0) ? e_rel + abort_off : -1;

    c = 0;
    while (1) begin
      if (c == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, lights, result_valid, false_start, react_ms, delay_ms} !== '0) begin
          failures++;
          $display("FAIL async_reset got=%h want=0",
                   {busy, lights, result_valid, false_start, react_ms, delay_ms});
        end
        trigger = 1'b0;
        react = 1'b0;
        m_idle = 1'b1;
        m_delay = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (c == done) break;
      exp_l = model_lights(c, e_rel);
      exp_d = (c >= HOLD_REL) ? best : m_delay;
      exp_v = {1'b1, exp_l, 1'b0, 1'b0, {RW{1'b0}}, exp_d};
      act_v = {busy, lights, result_valid, false_start, react_ms, delay_ms};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL run_cycle c=%0d got=%h want=%h", c, act_v, exp_v);
      end
      if (c == 1 || c == trig_edge + 1) trigger = 1'b0;
      if (trig_edge != 0 && c == trig_edge - 1) trigger = 1'b1;
      if (same_react && c == 0) react = 1'b0;
      if (r > 0 && c == r - 1) react = 1'b1;
      @(negedge clk);
      c++;
    end

    // result at the finishing edge
    if (fs) begin
      exp_d = (r > HOLD_REL) ? best : m_delay;
      exp_v = {1'b0, {NL{1'b1}}, 1'b0, 1'b1, {RW{1'b0}}, exp_d};
    end else begin
      exp_d = best;
      exp_v = {1'b0, {NL{1'b0}}, 1'b1, 1'b0, RW'(rms), exp_d};
    end
    act_v = {busy, lights, result_valid, false_start, react_ms, delay_ms};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL run_result c=%0d got=%h want=%h", c, act_v, exp_v);
    end
    m_delay = exp_d;
    react = 1'b0;
    trigger = 1'b0;
    m_idle = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    trigger = 1'b0;
    react = 1'b0;
    m_idle = 1'b1;
    m_delay = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, lights, result_valid, false_start, react_ms, delay_ms} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0",
               {busy, lights, result_valid, false_start, react_ms, delay_ms});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, lights, result_valid, false_start} !== '0) begin
      failures++;
      $display("FAIL idle_after_reset got=%h want=0", {busy, lights, result_valid, false_start});
    end
  endtask

  task automatic test_clean_run();
    do_run(2, 21, 1'b0, 0, 0, $urandom_range(0, 30));
  endtask

  task automatic test_false_start();
    do_run(1, 20, 1'b0, 0, 0, $urandom_range(0, 30));
    do_run(1, 8, 1'b0, 0, 0, $urandom_range(0, 30));
    do_run(1, HOLD_REL, 1'b0, 0, 0, $urandom_range(0, 30));
    do_run(2, 0, 1'b0, 0, 0, $urandom_range(0, 30));
    do_run(2, 1, 1'b0, 0, 0, $urandom_range(0, 30));
  endtask

  task automatic test_timeout();
    do_run(0, 0, 1'b0, 0, 0, $urandom_range(0, 30));
    do_run(2, TIMEOUT, 1'b0, 0, 0, $urandom_range(0, 30));
  endtask

  task automatic test_priority();
    do_run(2, 30, 1'b1, 0, 0, $urandom_range(0, 30));
    do_run(2, 12, 1'b0, HOLD_REL + 2, 0, $urandom_range(0, 30));
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 0)
        do_run(1, $urandom_range(1, 60), 1'b0, 0, 0, $urandom_range(0, 40));
      else
        do_run(2, $urandom_range(0, 270), 1'b0, 0, 0, $urandom_range(0, 40));
    end
  endtask

  task automatic test_lfsr_long();
    repeat (16384) @(negedge clk);
    do_run(2, $urandom_range(1, 40), 1'b0, 0, 0, 0);
    checks++;
    if (delay_ms === '0) begin
      failures++;
      $display("FAIL lfsr_nonzero got=%0d want=nonzero", delay_ms);
    end
  endtask

  task automatic test_reset_mid_timing();
    do_run(0, 0, 1'b0, 0, 10, $urandom_range(0, 30));
    do_run(2, $urandom_range(1, 100), 1'b0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    do_run(2, $urandom_range(1, 50), 1'b0, 0, 0, 0);
    do_run(1, $urandom_range(2, 30), 1'b0, 0, 0, 0);
    do_run(2, $urandom_range(1, 50), 1'b0, 0, 0, 0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_clean_run();
    test_false_start();
    test_timeout();
    test_priority();
    test_random();
    test_lfsr_long();
    test_reset_mid_timing();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
